// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the IF/DM unified-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned MAX_MEM_LATENCY = 15;
  localparam int unsigned LAT_W           = $clog2(MAX_MEM_LATENCY + 1);
  localparam int unsigned IF_W            = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the unified memory arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) ();
  import mem_arb_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [IF_W-1:0]   if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arb_timer.sv
// Loadable down-counter; done_c flags the last cycle of the memory wait.
module mem_arb_timer
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic             done_c
);

  logic [LAT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

  assign done_c = (cnt == LAT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between the instruction-fetch
// and load/store ports, one transaction at a time, with DM priority and IF anti-starvation.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t          state;
  owner_t              owner;
  logic                lat_we;
  logic [STARVE_W-1:0] starve_cnt;

  logic                if_grant_c;
  logic                dm_grant_c;
  logic                timer_load_c;
  logic                timer_done_c;
  logic [STARVE_W-1:0] starve_inc_c;

  mem_arb_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load_c),
    .load_val (LAT_W'(MEM_LATENCY)),
    .done_c   (timer_done_c)
  );

  assign timer_load_c = (state == ACCESS);
  assign starve_inc_c = (starve_cnt == STARVE_W'(STARVE_LIMIT)) ? starve_cnt
                                                                 : starve_cnt + STARVE_W'(1);

  // Grant decision: fresh arbitration in IDLE, hand-off to the other port in RESP.
  always_comb begin
    if_grant_c = 1'b0;
    dm_grant_c = 1'b0;
    case (state)
      IDLE: begin
        if (bus.if_req && bus.dm_req) begin
          if (starve_cnt == STARVE_W'(STARVE_LIMIT)) if_grant_c = 1'b1;
          else                                       dm_grant_c = 1'b1;
        end else begin
          if_grant_c = bus.if_req;
          dm_grant_c = bus.dm_req;
        end
      end
      RESP: begin
        if (owner == OWN_DM) if_grant_c = bus.if_req;
        else                 dm_grant_c = bus.dm_req;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= OWN_IF;
      lat_we        <= 1'b0;
      starve_cnt    <= '0;
      bus.if_ack    <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_ack    <= 1'b0;
      bus.dm_rdata  <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.mem_en <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.if_ack <= 1'b0;
      bus.dm_ack <= 1'b0;

      // mem_addr/mem_wdata double as the request latch for the whole transaction.
      if (if_grant_c || dm_grant_c) begin
        owner         <= if_grant_c ? OWN_IF : OWN_DM;
        lat_we        <= dm_grant_c & bus.dm_we;
        bus.mem_en    <= 1'b1;
        bus.mem_we    <= dm_grant_c & bus.dm_we;
        bus.mem_addr  <= if_grant_c ? ADDR_W'(bus.if_addr) : ADDR_W'(bus.dm_addr);
        if (dm_grant_c) bus.mem_wdata <= DATA_W'(bus.dm_wdata);
        state         <= ACCESS;
        bus.busy      <= 1'b1;
      end

      if (if_grant_c)                        starve_cnt <= '0;
      else if (dm_grant_c)                   starve_cnt <= bus.if_req ? starve_inc_c : '0;
      else if (state == IDLE && !bus.if_req) starve_cnt <= '0;

      case (state)
        ACCESS: state <= WAIT;
        WAIT: begin
          if (timer_done_c) begin
            state <= RESP;
            if (owner == OWN_IF) begin
              bus.if_ack   <= 1'b1;
              bus.if_rdata <= bus.mem_addr[2] ? bus.mem_rdata[2*IF_W-1:IF_W]
                                              : bus.mem_rdata[IF_W-1:0];
            end else begin
              bus.dm_ack <= 1'b1;
              if (!lat_we) bus.dm_rdata <= DATA_W'(bus.mem_rdata);
            end
          end
        end
        RESP: begin
          if (!(if_grant_c || dm_grant_c)) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at latency 1 with a small
// memory model, one at latency 3 with hand-driven read data.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b3 ();

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave)
  );

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b3.slave)
  );

  // One-cycle-latency memory for the first instance, word-indexed.
  logic [63:0] mem [0:511];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 512; i++) mem[i] <= 64'h0;
      mem[9'h020]  <= 64'hDEADBEEF_00000013;
      mem[9'h021]  <= 64'hCAFEF00D_0BADC0DE;
      b1.mem_rdata <= 64'h0;
    end else if (b1.mem_en) begin
      if (b1.mem_we) mem[b1.mem_addr[11:3]] <= b1.mem_wdata;
      b1.mem_rdata <= mem[b1.mem_addr[11:3]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(input string who, input logic [63:0] ack_if, input logic [63:0] ack_dm,
                          input logic [63:0] ird, input logic [63:0] drd, input logic [63:0] men,
                          input logic [63:0] madr, input logic [63:0] bsy);
    chk({who, " if_ack"}, ack_if, 64'h0);
    chk({who, " dm_ack"}, ack_dm, 64'h0);
    chk({who, " if_rdata"}, ird, 64'h0);
    chk({who, " dm_rdata"}, drd, 64'h0);
    chk({who, " mem_en"}, men, 64'h0);
    chk({who, " mem_addr"}, madr, 64'h0);
    chk({who, " busy"}, bsy, 64'h0);
  endtask

  initial begin
    reset = 1'b1;
    b1.if_req = 1'b0; b1.if_addr = '0; b1.dm_req = 1'b0; b1.dm_we = 1'b0;
    b1.dm_addr = '0; b1.dm_wdata = '0;
    b3.if_req = 1'b0; b3.if_addr = '0; b3.dm_req = 1'b0; b3.dm_we = 1'b0;
    b3.dm_addr = '0; b3.dm_wdata = '0; b3.mem_rdata = '0;

    tick(2);
    chk_zero("reset1", 64'(b1.if_ack), 64'(b1.dm_ack), 64'(b1.if_rdata), b1.dm_rdata,
             64'(b1.mem_en), b1.mem_addr, 64'(b1.busy));
    chk_zero("reset3", 64'(b3.if_ack), 64'(b3.dm_ack), 64'(b3.if_rdata), b3.dm_rdata,
             64'(b3.mem_en), b3.mem_addr, 64'(b3.busy));
    @(negedge clk) reset = 1'b0;
    tick();

    // Single IF read, high half selected by addr[2].
    b1.if_req = 1'b1; b1.if_addr = 64'h104;
    chk("t1 busy c0", 64'(b1.busy), 64'h0);
    tick();
    chk("t1 mem_en c1", 64'(b1.mem_en), 64'h1);
    chk("t1 mem_addr c1", b1.mem_addr, 64'h104);
    chk("t1 mem_we c1", 64'(b1.mem_we), 64'h0);
    tick();
    chk("t1 if_ack c2", 64'(b1.if_ack), 64'h0);
    chk("t1 mem_en c2", 64'(b1.mem_en), 64'h0);
    tick();
    chk("t1 if_ack c3", 64'(b1.if_ack), 64'h1);
    chk("t1 if_rdata", 64'(b1.if_rdata), 64'hDEADBEEF);
    b1.if_req = 1'b0;
    tick();
    chk("t1 if_ack c4", 64'(b1.if_ack), 64'h0);
    chk("t1 busy c4", 64'(b1.busy), 64'h0);

    // DM store then load of the same address.
    b1.dm_req = 1'b1; b1.dm_we = 1'b1; b1.dm_addr = 64'h200; b1.dm_wdata = 64'h1122334455667788;
    tick();
    chk("t2 st mem_en", 64'(b1.mem_en), 64'h1);
    chk("t2 st mem_we", 64'(b1.mem_we), 64'h1);
    chk("t2 st mem_addr", b1.mem_addr, 64'h200);
    chk("t2 st mem_wdata", b1.mem_wdata, 64'h1122334455667788);
    b1.dm_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(2);
    chk("t2 st dm_ack", 64'(b1.dm_ack), 64'h1);
    chk("t2 st dm_rdata held", b1.dm_rdata, 64'h0);
    b1.dm_we = 1'b0;
    tick();
    chk("t2 gap busy", 64'(b1.busy), 64'h0);
    tick();
    chk("t2 ld mem_we", 64'(b1.mem_we), 64'h0);
    tick(2);
    chk("t2 ld dm_ack", 64'(b1.dm_ack), 64'h1);
    chk("t2 ld dm_rdata", b1.dm_rdata, 64'h1122334455667788);
    b1.dm_req = 1'b0;
    tick();

    // Both held: DM first, then alternating hand-offs with no IDLE bubble.
    b1.if_req = 1'b1; b1.if_addr = 64'h100; b1.dm_req = 1'b1;
    tick();
    chk("t3 g1 mem_addr", b1.mem_addr, 64'h200);
    tick(2);
    chk("t3 dm_ack c3", 64'(b1.dm_ack), 64'h1);
    chk("t3 if_ack c3", 64'(b1.if_ack), 64'h0);
    chk("t3 busy c3", 64'(b1.busy), 64'h1);
    tick();
    chk("t3 g2 mem_en", 64'(b1.mem_en), 64'h1);
    chk("t3 g2 mem_addr", b1.mem_addr, 64'h100);
    chk("t3 busy c4", 64'(b1.busy), 64'h1);
    tick(2);
    chk("t3 if_ack c6", 64'(b1.if_ack), 64'h1);
    chk("t3 dm_ack c6", 64'(b1.dm_ack), 64'h0);
    chk("t3 if_rdata", 64'(b1.if_rdata), 64'h00000013);
    tick();
    chk("t3 g3 mem_addr", b1.mem_addr, 64'h200);
    tick(2);
    chk("t3 dm_ack c9", 64'(b1.dm_ack), 64'h1);
    tick();
    chk("t3 g4 mem_addr", b1.mem_addr, 64'h100);
    b1.if_req = 1'b0; b1.dm_req = 1'b0;
    tick(2);
    chk("t3 if_ack c12 dropped req", 64'(b1.if_ack), 64'h1);
    tick();
    chk("t3 busy c13", 64'(b1.busy), 64'h0);

    // Starvation: IF requesting at each of four DM arbitrations, IF wins the fifth.
    b1.dm_req = 1'b1; b1.if_addr = 64'h108;
    for (int g = 0; g < 4; g++) begin
      b1.if_req = 1'b1;
      tick();
      b1.if_req = 1'b0;
      chk($sformatf("t4 dm grant %0d", g), b1.mem_addr, 64'h200);
      tick(2);
      chk($sformatf("t4 dm ack %0d", g), 64'(b1.dm_ack), 64'h1);
      tick();
    end
    b1.if_req = 1'b1;
    tick();
    chk("t4 if wins 5th", b1.mem_addr, 64'h108);
    tick(2);
    chk("t4 if_ack", 64'(b1.if_ack), 64'h1);
    chk("t4 if_rdata", 64'(b1.if_rdata), 64'h0BADC0DE);
    b1.if_req = 1'b0;
    tick();
    chk("t4 handoff mem_addr", b1.mem_addr, 64'h200);
    chk("t4 handoff mem_en", 64'(b1.mem_en), 64'h1);
    b1.dm_req = 1'b0;
    tick(2);
    chk("t4 last dm_ack", 64'(b1.dm_ack), 64'h1);
    tick();
    chk("t4 busy idle", 64'(b1.busy), 64'h0);

    // Latency 3: only the word present on the final WAIT cycle is captured.
    b3.if_req = 1'b1; b3.if_addr = 64'h4;
    tick();
    chk("t5 mem_en c1", 64'(b3.mem_en), 64'h1);
    chk("t5 mem_addr c1", b3.mem_addr, 64'h4);
    tick();
    b3.mem_rdata = 64'h1111_2222_3333_4444;
    chk("t5 if_ack c2", 64'(b3.if_ack), 64'h0);
    tick();
    b3.mem_rdata = 64'h5555_6666_7777_8888;
    chk("t5 if_ack c3", 64'(b3.if_ack), 64'h0);
    tick();
    b3.mem_rdata = 64'hA5A5_5A5A_0123_4567;
    chk("t5 if_ack c4", 64'(b3.if_ack), 64'h0);
    chk("t5 busy c4", 64'(b3.busy), 64'h1);
    tick();
    chk("t5 if_ack c5", 64'(b3.if_ack), 64'h1);
    chk("t5 if_rdata", 64'(b3.if_rdata), 64'hA5A55A5A);
    b3.if_req = 1'b0; b3.mem_rdata = 64'h9999_9999_9999_9999;
    tick();
    chk("t5 if_ack c6", 64'(b3.if_ack), 64'h0);
    chk("t5 if_rdata hold", 64'(b3.if_rdata), 64'hA5A55A5A);

    // Asynchronous reset in the middle of WAIT drops the transaction.
    b3.dm_req = 1'b1; b3.dm_we = 1'b0; b3.dm_addr = 64'h10;
    tick();
    chk("t6 mem_en c1", 64'(b3.mem_en), 64'h1);
    tick();
    #2 reset = 1'b1;
    #1;
    chk_zero("t6 async3", 64'(b3.if_ack), 64'(b3.dm_ack), 64'(b3.if_rdata), b3.dm_rdata,
             64'(b3.mem_en), b3.mem_addr, 64'(b3.busy));
    chk_zero("t6 async1", 64'(b1.if_ack), 64'(b1.dm_ack), 64'(b1.if_rdata), b1.dm_rdata,
             64'(b1.mem_en), b1.mem_addr, 64'(b1.busy));
    b3.dm_req = 1'b0;
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("t6 no dm_ack %0d", k), 64'(b3.dm_ack), 64'h0);
      chk($sformatf("t6 busy %0d", k), 64'(b3.busy), 64'h0);
    end

    b3.if_req = 1'b1; b3.if_addr = 64'h0; b3.mem_rdata = 64'h0BADF00D_76543210;
    tick(4);
    chk("t6 new if_ack c4", 64'(b3.if_ack), 64'h0);
    tick();
    chk("t6 new if_ack c5", 64'(b3.if_ack), 64'h1);
    chk("t6 new if_rdata", 64'(b3.if_rdata), 64'h76543210);
    b3.if_req = 1'b0;
    tick();
    chk("t6 busy end", 64'(b3.busy), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the instruction-fetch port (IF) and the load/store data port (DM).
- Arbitrates between the ports and sequences each access through a fixed-latency memory.
- Returns read data with a one-cycle ack pulse.
- Sits between the program counter / fetch logic and the data path, replacing separate instruction and data memories.

Parameters:
- ADDR_W, 64, byte address width.
- DATA_W, 64, memory word width.
- MEM_LATENCY, 1, cycles from the mem_en cycle to mem_rdata valid (legal range 1..15).
- STARVE_LIMIT, 4, consecutive DM grants allowed while IF is waiting (legal range ≥1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch byte address.
- if_ack  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  32  instruction word.
- dm_req  in  1  data request; held until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data byte address.
- dm_wdata  in  DATA_W  store data.
- dm_ack  out  1  one-cycle completion pulse.
- dm_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable, valid with mem_en.
- mem_addr  out  ADDR_W  memory address, valid with mem_en.
- mem_wdata  out  DATA_W  memory write data, valid with mem_en.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - All outputs go to 0, including if_rdata, dm_rdata and mem_addr.
  - Starvation counter and latency counter go to 0.
  - An in-flight transaction is dropped and never acked.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: arbitrate on sampled requests.
  - No request: stay in IDLE.
  - Only one request: that port wins.
  - Both requesting: DM wins, unless starve_cnt == STARVE_LIMIT, in which case IF wins.
  - On a grant: latch owner, address, we and wdata, then go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_en = 1.
  - mem_we = latched we; IF accesses always use we = 0.
  - mem_addr and mem_wdata come from the latch.
  - Latency counter loads MEM_LATENCY; go to WAIT.
- WAIT (MEM_LATENCY cycles):
  - Counter decrements each cycle.
  - When the counter reaches 1, capture mem_rdata at that clock edge and go to RESP.
- RESP (1 cycle):
  - The owner's ack = 1.
  - IF read: if_rdata = captured[63:32] when latched addr[2] = 1, else captured[31:0].
  - DM load: dm_rdata = captured word.
  - DM store: dm_rdata holds its previous value.
  - rdata outputs are registered and hold their value until the next read for that port.
- RESP exit:
  - If the non-owner port's req is high, go directly to ACCESS for it; no IDLE bubble.
  - Otherwise go to IDLE.
  - The owner's req is ignored in RESP. The requester deasserts req or re-presents a new request on the edge after ack.
- Latency:
  - req first high in IDLE at cycle c → ack at cycle c + MEM_LATENCY + 2.
  - Throughput: one transaction per MEM_LATENCY + 2 cycles, alternating ports back-to-back.
- Starvation counter:
  - Increments on each DM grant made while if_req = 1, saturating at STARVE_LIMIT.
  - Clears on any IF grant.
  - Clears on any arbitration where if_req = 0.
- Protocol violations:
  - Request dropped before ack: the transaction still completes and ack pulses anyway.
  - Address or data changed mid-transaction: the latched copy is used.
- Ack outputs are never high together. At most one transaction is outstanding.
- No alignment checking. Address bits [2:0] pass to mem_addr unmodified.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum: IDLE, ACCESS, WAIT, RESP.
  - owner_t enum: OWN_IF, OWN_DM.
  - Latency counter width constant LAT_W = $clog2(MEM_LATENCY+1).
- One sub-module, mem_arb_timer: loadable down-counter producing the done flag. All remaining logic (FSM, arbitration, datapath latches) stays in mem_port_arbiter.

Test Plan:
- Single IF read, MEM_LATENCY = 1:
  - Stimulus: if_addr = 0x104, memory returns 0xDEADBEEF_00000013.
  - Required: mem_en at cycle 1; if_ack at cycle 3; if_rdata = 0xDEADBEEF.
- DM store then load, same address:
  - Store dm_addr = 0x200, dm_wdata = 0x1122334455667788: mem_we = 1 in ACCESS; dm_ack pulses; dm_rdata unchanged.
  - Following load: dm_rdata = 0x1122334455667788.
- Simultaneous if_req and dm_req from IDLE:
  - DM is served first; RESP goes straight to ACCESS for IF.
  - Acks are 3 cycles apart (MEM_LATENCY = 1); busy stays high throughout.
- Starvation, STARVE_LIMIT = 4:
  - Stimulus: dm_req held continuously, if_req held continuously.
  - Required: grant order DM, IF, DM, IF alternating (RESP hand-off). With IF withheld until after 4 DM grants, then raised alongside DM, IF wins the 5th arbitration.
- MEM_LATENCY = 3:
  - Required: WAIT lasts exactly 3 cycles; ack 5 cycles after req.
  - mem_rdata changed during the first two WAIT cycles must not appear on the rdata outputs.
- Reset asserted asynchronously mid-WAIT:
  - Required: outputs 0 immediately; no ack ever issued for the dropped transaction.
  - After release, a new if_req completes normally.
